// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: 2-entry write-back FIFO draining one-hot writes into a register bank.
// Define WB_BYPASS_EN to forward queued and in-flight writes onto the read ports.
module regfile_wb_ctrl #(
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wb_valid,
  output logic                    wb_ready,
  input  logic [ADDR_W-1:0]       wb_addr,
  input  logic [DATA_W-1:0]       wb_data,
  input  logic                    bank_hold,
  output logic [NREGS-1:0]        bank_en,
  output logic [DATA_W-1:0]       bank_d,
  input  logic [NREGS*DATA_W-1:0] bank_q,
  input  logic [ADDR_W-1:0]       rd_addr_a,
  input  logic [ADDR_W-1:0]       rd_addr_b,
  output logic [DATA_W-1:0]       rd_data_a,
  output logic [DATA_W-1:0]       rd_data_b,
  output logic [1:0]              pending
);
  logic [ADDR_W-1:0] fa [2];
  logic [DATA_W-1:0] fd [2];
  logic wp, rp, push, pop;
  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] rv [2];
  assign wb_ready = !reset && pending != 2'd2;
  // register 0 writes complete the handshake but are dropped here
  assign push = wb_valid && wb_ready && wb_addr != '0;
  assign pop = pending != 2'd0 && !bank_hold;
  always_ff @(posedge clk)
    if (reset) begin
      wp <= 1'b0;
      rp <= 1'b0;
      pending <= 2'd0;
      bank_en <= '0;
      bank_d <= '0;
    end else begin
      if (push) begin
        fa[wp] <= wb_addr;
        fd[wp] <= wb_data;
        wp <= !wp;
      end
      if (pop) rp <= !rp;
      if (pop) bank_d <= fd[rp];
      pending <= pending + 2'(push) - 2'(pop);
      bank_en <= pop ? NREGS'(1) << fa[rp] : '0;
    end
  assign ra[0] = rd_addr_a;
  assign ra[1] = rd_addr_b;
  // later assignments win: newest entry beats older entry beats output stage beats bank
  always_comb
    for (int p = 0; p < 2; p++) begin
      rv[p] = bank_q[ra[p]*DATA_W +: DATA_W];
`ifdef WB_BYPASS_EN
      if (bank_en[ra[p]]) rv[p] = bank_d;
      if (pending == 2'd2 && fa[rp] == ra[p]) rv[p] = fd[rp];
      if (pending != 2'd0 && fa[!wp] == ra[p]) rv[p] = fd[!wp];
`endif
      if (ra[p] == '0) rv[p] = '0;
    end
  assign rd_data_a = rv[0];
  assign rd_data_b = rv[1];
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed vector table plus randomized run against a queue-based model.
module tb_regfile_wb_ctrl;
  localparam int NREGS = 32, ADDR_W = 5, DATA_W = 32;
  logic clk = 0, reset = 1, wb_valid = 0, bank_hold = 0, init = 1;
  logic wb_ready;
  logic [4:0] wb_addr = 0, rd_addr_a = 0, rd_addr_b = 0;
  logic [31:0] wb_data = 0, bank_d, rd_data_a, rd_data_b, bank_en;
  logic [1:0] pending;
  logic [NREGS*DATA_W-1:0] bank_q;
  logic [31:0] bank [NREGS];
  int checks = 0, fails = 0;
  typedef struct {logic [4:0] a; logic [31:0] d;} wr_t;
  wr_t q[$];
  logic [31:0] m_en = 0, m_d = 0;
  logic m_rdy;
  typedef struct {
    logic r, v, h;
    logic [4:0] a, ra, rb;
    logic [31:0] d;
    logic [1:0] ep;
    logic er;
    logic [31:0] een, ed;
  } vec_t;
  vec_t vt [24];

  always #5 clk = ~clk;

  regfile_wb_ctrl #(.NREGS(NREGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data), .bank_hold(bank_hold),
    .bank_en(bank_en), .bank_d(bank_d), .bank_q(bank_q),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .pending(pending)
  );

  // behavioural register bank; register 0 holds junk to prove reads of 0 are masked
  always @(posedge clk)
    for (int i = 0; i < NREGS; i++)
      if (init) bank[i] <= $urandom | 32'h1;
      else if (bank_en[i]) bank[i] <= bank_d;
  always_comb
    for (int i = 0; i < NREGS; i++) bank_q[i*DATA_W +: DATA_W] = bank[i];

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    logic [31:0] v = bank[a];
`ifdef WB_BYPASS_EN
    if (m_en[a]) v = m_d;
    foreach (q[i]) if (q[i].a == a) v = q[i].d;
`endif
    return a == 0 ? 32'h0 : v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic drive(input logic r, v, h, input logic [4:0] a, input logic [31:0] d,
                       input logic [4:0] ra, rb);
    reset = r; wb_valid = v; bank_hold = h; wb_addr = a; wb_data = d;
    rd_addr_a = ra; rd_addr_b = rb;
    #1;
  endtask

  task automatic model_check();
    m_rdy = !reset && q.size() < 2;
    chk("wb_ready", 32'(wb_ready), 32'(m_rdy));
    chk("pending", 32'(pending), q.size());
    chk("bank_en", bank_en, m_en);
    chk("bank_d", bank_d, m_d);
    chk("rd_data_a", rd_data_a, exp_rd(rd_addr_a));
    chk("rd_data_b", rd_data_b, exp_rd(rd_addr_b));
  endtask

  task automatic edge_step();
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_en = 0;
      m_d = 0;
    end else begin
      if (q.size() > 0 && !bank_hold) begin
        m_en = 32'd1 << q[0].a;
        m_d = q[0].d;
        void'(q.pop_front());
      end else m_en = 0;
      if (wb_valid && m_rdy && wb_addr != 0) q.push_back('{wb_addr, wb_data});
    end
    @(negedge clk);
  endtask

  initial begin
    vt = '{
      '{1,1,0,5,5,3,32'hAA,      0,0,0,0},
      '{1,1,0,5,5,3,32'hAA,      0,0,0,0},
      '{0,1,0,5,5,3,32'hDEADBEEF,0,1,0,0},
      '{0,0,0,0,5,3,0,           1,1,0,0},
      '{0,0,0,0,5,3,0,           0,1,32'h20,32'hDEADBEEF},
      '{0,1,0,0,0,5,32'h1234,    0,1,0,32'hDEADBEEF},
      '{0,0,0,0,0,5,0,           0,1,0,32'hDEADBEEF},
      '{0,1,1,3,3,0,32'h11,      0,1,0,32'hDEADBEEF},
      '{0,1,1,3,3,0,32'h22,      1,1,0,32'hDEADBEEF},
      '{0,1,1,7,3,7,32'h77,      2,0,0,32'hDEADBEEF},
      '{0,1,1,7,3,7,32'h77,      2,0,0,32'hDEADBEEF},
      '{0,0,0,0,3,7,0,           2,0,0,32'hDEADBEEF},
      '{0,0,0,0,3,7,0,           1,1,8,32'h11},
      '{0,0,0,0,3,7,0,           0,1,8,32'h22},
      '{0,1,0,1,1,2,32'h101,     0,1,0,32'h22},
      '{0,1,0,2,1,2,32'h102,     1,1,0,32'h22},
      '{0,1,0,4,2,4,32'h104,     1,1,2,32'h101},
      '{0,0,0,0,2,4,0,           1,1,4,32'h102},
      '{0,0,0,0,4,1,0,           0,1,32'h10,32'h104},
      '{0,1,1,9,9,10,32'h99,     0,1,0,32'h104},
      '{0,1,1,10,9,10,32'hAA,    1,1,0,32'h104},
      '{1,0,0,0,9,10,0,          2,0,0,32'h104},
      '{0,0,0,0,9,10,0,          0,1,0,0},
      '{0,0,0,0,9,10,0,          0,1,0,0}
    };
    @(posedge clk);
    init = 0;
    @(posedge clk);
    @(negedge clk);
    foreach (vt[i]) begin
      drive(vt[i].r, vt[i].v, vt[i].h, vt[i].a, vt[i].d, vt[i].ra, vt[i].rb);
      chk($sformatf("tbl%0d_pending", i), 32'(pending), 32'(vt[i].ep));
      chk($sformatf("tbl%0d_ready", i), 32'(wb_ready), 32'(vt[i].er));
      chk($sformatf("tbl%0d_en", i), bank_en, vt[i].een);
      chk($sformatf("tbl%0d_d", i), bank_d, vt[i].ed);
      model_check();
      edge_step();
    end
    for (int n = 0; n < 800; n++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      model_check();
      edge_step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
